ysyx_ifq: RTL and testbench

Instruction fetch queue between the IFU and the IDU. It decouples instruction delivery from decode stalls by buffering up to DEPTH `{pc, inst}` pairs in a circular FIFO. Each entry carries pre-decoded class flags so the IDU does not recompute them. A flush discards all buffered entries when the IFU resolves a bad speculation.

---
 rtl/ysyx_ifq.sv | 123 ++++++++++++
 tb/tb_ysyx_ifq.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/ysyx_ifq.sv
// ysyx_ifq: instruction fetch queue between the IFU and the IDU.
// A circular FIFO of {pc, inst, pre-decode} entries. Flush or reset
// empties the queue in one cycle. Handshake outputs come straight from
// registered state, so there is no combinational path from next_ready
// to ready_o and no bypass from inst_i to the head.
module ysyx_ifq #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       flush_i,
  input  logic                       prev_valid,
  input  logic [DATA_W-1:0]          inst_i,
  input  logic [DATA_W-1:0]          pc_i,
  output logic                       ready_o,
  output logic                       valid_o,
  output logic [DATA_W-1:0]          inst_o,
  output logic [DATA_W-1:0]          pc_o,
  output logic [3:0]                 pdec_o,
  input  logic                       next_ready,
  output logic [$clog2(DEPTH):0]     count_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL_CNT  = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] EMPTY_CNT = CNT_W'(0);
  localparam logic [CNT_W-1:0] ONE_CNT   = CNT_W'(1);
  localparam logic [PTR_W-1:0] ONE_PTR   = PTR_W'(1);
  localparam logic [PTR_W-1:0] ZERO_PTR  = PTR_W'(0);

  // Pre-decode flags {is_fence_i, is_store, is_load, is_branch}.
  // Jumps and SYSTEM are grouped with branches because all of them can
  // redirect the fetch stream.
  function automatic logic [3:0] pre_decode(input logic [DATA_W-1:0] inst);
    logic [6:0] opcode;
    logic       is_branch;
    logic       is_load;
    logic       is_store;
    logic       is_fence_i;
    opcode     = inst[6:0];
    is_branch  = 1'b0;
    is_load    = 1'b0;
    is_store   = 1'b0;
    case (opcode)
      7'b1101111,
      7'b1100111,
      7'b1100011,
      7'b1110011: is_branch = 1'b1;
      7'b0000011: is_load   = 1'b1;
      7'b0100011: is_store  = 1'b1;
      default: begin
        is_branch = 1'b0;
        is_load   = 1'b0;
        is_store  = 1'b0;
      end
    endcase
    is_fence_i = (inst == DATA_W'(32'h0000100f));
    return {is_fence_i, is_store, is_load, is_branch};
  endfunction

  logic [DATA_W-1:0] inst_q [DEPTH];
  logic [DATA_W-1:0] pc_q   [DEPTH];
  logic [3:0]        pdec_q [DEPTH];

  logic [PTR_W-1:0]  wp_r;
  logic [PTR_W-1:0]  rp_r;
  logic [CNT_W-1:0]  cnt_r;
  logic [CNT_W-1:0]  cnt_nxt_s;
  logic              push_s;
  logic              pop_s;

  // Handshakes derive only from the registered occupancy.
  assign ready_o = (cnt_r != FULL_CNT);
  assign valid_o = (cnt_r != EMPTY_CNT);
  assign count_o = cnt_r;

  assign inst_o  = inst_q[rp_r];
  assign pc_o    = pc_q[rp_r];
  assign pdec_o  = pdec_q[rp_r];

  // A flush suppresses both handshakes, even if they are high.
  assign push_s = prev_valid & ready_o & ~flush_i;
  assign pop_s  = valid_o & next_ready & ~flush_i;

  // Next occupancy: simultaneous push and pop leave the count unchanged.
  always_comb begin
    cnt_nxt_s = cnt_r;
    case ({push_s, pop_s})
      2'b10:   cnt_nxt_s = cnt_r + ONE_CNT;
      2'b01:   cnt_nxt_s = cnt_r - ONE_CNT;
      default: cnt_nxt_s = cnt_r;
    endcase
  end

  // Pointer and count state; reset beats flush, flush beats push/pop.
  always_ff @(posedge clk) begin
    if (rst || flush_i) begin
      wp_r  <= ZERO_PTR;
      rp_r  <= ZERO_PTR;
      cnt_r <= EMPTY_CNT;
    end else begin
      if (push_s) begin
        wp_r <= wp_r + ONE_PTR;
      end
      if (pop_s) begin
        rp_r <= rp_r + ONE_PTR;
      end
      cnt_r <= cnt_nxt_s;
    end
  end

  // Entry storage; contents are never cleared, only the pointers are.
  always_ff @(posedge clk) begin
    if (push_s && !rst) begin
      inst_q[wp_r] <= inst_i;
      pc_q[wp_r]   <= pc_i;
      pdec_q[wp_r] <= pre_decode(inst_i);
    end
  end

endmodule

// File: tb/tb_ysyx_ifq.sv
// Testbench for ysyx_ifq: directed scenarios followed by random traffic,
// checked against a queue-based reference model of the fetch queue.
module tb_ysyx_ifq;

  localparam int DATA_W = 32;
  localparam int DEPTH  = 4;
  localparam int CNT_W  = $clog2(DEPTH) + 1;

  logic              clk = 1'b0;
  logic              rst;
  logic              flush_i;
  logic              prev_valid;
  logic [DATA_W-1:0] inst_i;
  logic [DATA_W-1:0] pc_i;
  logic              ready_o;
  logic              valid_o;
  logic [DATA_W-1:0] inst_o;
  logic [DATA_W-1:0] pc_o;
  logic [3:0]        pdec_o;
  logic              next_ready;
  logic [CNT_W-1:0]  count_o;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] inst;
    logic [3:0]  pdec;
  } ent_t;

  ent_t model_q[$];
  int   tests = 0;
  int   fails = 0;
  bit   started = 1'b0;

  ysyx_ifq #(.DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
    .clk        (clk),
    .rst        (rst),
    .flush_i    (flush_i),
    .prev_valid (prev_valid),
    .inst_i     (inst_i),
    .pc_i       (pc_i),
    .ready_o    (ready_o),
    .valid_o    (valid_o),
    .inst_o     (inst_o),
    .pc_o       (pc_o),
    .pdec_o     (pdec_o),
    .next_ready (next_ready),
    .count_o    (count_o)
  );

  always #5 clk = ~clk;

  // Reference classification straight from the instruction encoding rules.
  function automatic logic [3:0] ref_pdec(input logic [31:0] inst);
    logic [6:0] op;
    logic [3:0] r;
    op = inst[6:0];
    r = 4'b0000;
    if (op == 7'h6f || op == 7'h67 || op == 7'h63 || op == 7'h73) r[0] = 1'b1;
    if (op == 7'h03) r[1] = 1'b1;
    if (op == 7'h23) r[2] = 1'b1;
    if (inst == 32'h0000100f) r[3] = 1'b1;
    return r;
  endfunction

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  // Apply one cycle of inputs just after the rising edge.
  task automatic step(input logic pv, input logic [31:0] pc, input logic [31:0] inst,
                      input logic nr, input logic fl, input logic r);
    prev_valid = pv;
    pc_i       = pc;
    inst_i     = inst;
    next_ready = nr;
    flush_i    = fl;
    rst        = r;
    @(posedge clk);
    #1;
  endtask

  // Monitor/scoreboard: on the falling edge compare outputs with the model,
  // then apply this cycle's accepted push/pop/flush/reset to the model.
  always @(negedge clk) begin : mon
    int   sz;
    bit   do_push;
    bit   do_pop;
    ent_t e;
    if (started) begin
      sz = model_q.size();
      check("count_o", 64'(count_o), 64'(sz));
      check("valid_o", 64'(valid_o), 64'(sz != 0));
      check("ready_o", 64'(ready_o), 64'(sz != DEPTH));
      if (sz != 0) begin
        check("head_pc",   64'(pc_o),   64'(model_q[0].pc));
        check("head_inst", 64'(inst_o), 64'(model_q[0].inst));
        check("head_pdec", 64'(pdec_o), 64'(model_q[0].pdec));
      end
      do_push = prev_valid && (sz != DEPTH) && !flush_i && !rst;
      do_pop  = (sz != 0) && next_ready && !flush_i && !rst;
      if (rst || flush_i) begin
        model_q.delete();
      end else begin
        if (do_pop) void'(model_q.pop_front());
        if (do_push) begin
          e.pc   = pc_i;
          e.inst = inst_i;
          e.pdec = ref_pdec(inst_i);
          model_q.push_back(e);
        end
      end
    end
  end

  logic [31:0] pdec_insts [5];
  logic [31:0] ops [8];

  initial begin
    logic [31:0] pc;
    logic [31:0] ins;
    pdec_insts[0] = 32'h0000006f; pdec_insts[1] = 32'h00002083;
    pdec_insts[2] = 32'h00112023; pdec_insts[3] = 32'h0000100f;
    pdec_insts[4] = 32'h00000013;
    ops[0] = 32'h6f; ops[1] = 32'h67; ops[2] = 32'h63; ops[3] = 32'h73;
    ops[4] = 32'h03; ops[5] = 32'h23; ops[6] = 32'h13; ops[7] = 32'h0f;

    step(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b1);
    started = 1'b1;
    step(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b1);

    // Basic order: three pushes with the IDU stalled, then drain.
    for (int i = 0; i < 3; i++) step(1'b1, 32'h80000000 + 32'(4 * i), 32'h00000013, 1'b0, 1'b0, 1'b0);
    step(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
    step(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0);
    step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0);

    // Fill and backpressure: fifth push must be refused.
    for (int i = 0; i < 5; i++) step(1'b1, 32'h80000010 + 32'(4 * i), 32'h00000013, 1'b0, 1'b0, 1'b0);
    step(1'b1, 32'h80000050, 32'h00000013, 1'b1, 1'b0, 1'b0);
    step(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0);

    // Streaming across the pointer wrap.
    for (int i = 0; i < 10; i++) step(1'b1, 32'h80000000 + 32'(4 * i), 32'h00000013, 1'b1, 1'b0, 1'b0);
    step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0);

    // Pre-decode classes.
    for (int i = 0; i < 5; i++) step(1'b1, 32'h80000200 + 32'(4 * i), pdec_insts[i], 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0);

    // Flush with concurrent push and pop.
    for (int i = 0; i < 3; i++) step(1'b1, 32'h80000300 + 32'(4 * i), 32'h00000013, 1'b0, 1'b0, 1'b0);
    step(1'b1, 32'hdeadbeec, 32'h00000013, 1'b1, 1'b1, 1'b0);
    step(1'b1, 32'h80000100, 32'h00000013, 1'b0, 1'b0, 1'b0);
    step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0);

    // Flush while full with an offered instruction.
    for (int i = 0; i < 4; i++) step(1'b1, 32'h80000400 + 32'(4 * i), 32'h00000013, 1'b0, 1'b0, 1'b0);
    step(1'b1, 32'hdeadbee0, 32'h00000013, 1'b0, 1'b1, 1'b0);

    // Reset mid-stream with two entries held.
    for (int i = 0; i < 2; i++) step(1'b1, 32'h80000500 + 32'(4 * i), 32'h00000013, 1'b0, 1'b0, 1'b0);
    step(1'b1, 32'hdeadbee4, 32'h00000013, 1'b1, 1'b0, 1'b1);
    step(1'b1, 32'h80000600, 32'h00002083, 1'b0, 1'b0, 1'b0);
    step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0);

    // Random traffic.
    pc = 32'h80001000;
    for (int i = 0; i < 600; i++) begin
      ins = ($urandom() & 32'hffffff80) | ops[$urandom_range(0, 7)];
      if ($urandom_range(0, 15) == 0) ins = 32'h0000100f;
      step(1'($urandom_range(0, 1)), pc, ins, 1'($urandom_range(0, 2) != 0),
           1'($urandom_range(0, 24) == 0), 1'($urandom_range(0, 60) == 0));
      pc = pc + 32'd4;
    end
    step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0);
    @(negedge clk);
    #1;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
